// File: rtl/mm_tile_engine.sv
// Output-stationary tile multiplier: C = A*B (+ result_in when acc_mode), streamed A/B load over req/grant.
// Optional build macro MM_SATURATE_EN: saturate the narrowed result instead of wrapping.
//
// state     | meaning
// ----------+----------------------------------------------------
// S_IDLE    | waiting for en; result_out/tag_out hold last tile
// S_LOAD    | accepting A and B words on independent channels
// S_COMPUTE | KDIM MAC steps, all cells in parallel
// S_WRITE   | add optional bias, narrow, register result, pulse done
module mm_tile_engine #(
    parameter int WIDTH = 16,
    parameter int ROW   = 4,
    parameter int COL   = 4,
    parameter int KDIM  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         acc_mode,
    input  logic [23:0]                  tag_in,
    input  logic                         grant_in,
    input  logic                         grant_w,
    input  logic [WIDTH-1:0]             data_in_a,
    input  logic [WIDTH-1:0]             data_in_b,
    input  logic [ROW*COL*WIDTH-1:0]     result_in,
    output logic                         req_in,
    output logic                         req_w,
    output logic                         busy,
    output logic                         done,
    output logic [ROW*COL*WIDTH-1:0]     result_out,
    output logic [23:0]                  tag_out
);
    localparam int AW = 2*WIDTH + $clog2(KDIM) + 1;
    localparam int KW = $clog2(KDIM);
    localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int CW = (COL > 1) ? $clog2(COL) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_COMPUTE = 2'd2;
    localparam logic [1:0] S_WRITE   = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_mem [ROW][KDIM];
    logic [WIDTH-1:0] b_mem [KDIM][COL];
    logic [AW-1:0]    acc   [ROW][COL];
    logic             acc_mode_q;
    logic [23:0]      tag_q;
    logic [RW-1:0]    a_r;
    logic [KW-1:0]    a_k;
    logic [KW-1:0]    b_k;
    logic [CW-1:0]    b_c;
    logic [KW-1:0]    k_cnt;

    logic a_take, b_take, a_last, b_last, a_fin, b_fin;
    logic [ROW*COL*WIDTH-1:0] result_nxt;

    function automatic logic [AW-1:0] mac_term(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] p;
        p = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        return {{(AW-2*WIDTH){p[2*WIDTH-1]}}, p};
    endfunction

    function automatic logic [AW-1:0] sext_w(input logic [WIDTH-1:0] e);
        return {{(AW-WIDTH){e[WIDTH-1]}}, e};
    endfunction

    function automatic logic [WIDTH-1:0] narrow(input logic [AW-1:0] s);
`ifdef MM_SATURATE_EN
        logic [AW-1:0] sat_max;
        logic [AW-1:0] sat_min;
        sat_max = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
        sat_min = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
        if ($signed(s) > $signed(sat_max))
            return sat_max[WIDTH-1:0];
        else if ($signed(s) < $signed(sat_min))
            return sat_min[WIDTH-1:0];
        else
            return s[WIDTH-1:0];
`else
        return s[WIDTH-1:0];
`endif
    endfunction

    assign a_take = (state == S_LOAD) && req_in && grant_in;
    assign b_take = (state == S_LOAD) && req_w && grant_w;
    assign a_last = a_take && (a_r == RW'(ROW-1)) && (a_k == KW'(KDIM-1));
    assign b_last = b_take && (b_k == KW'(KDIM-1)) && (b_c == CW'(COL-1));
    // A channel is finished if it already was, or if its final word lands this edge
    assign a_fin  = !req_in || a_last;
    assign b_fin  = !req_w || b_last;

    always_comb begin
        result_nxt = '0;
        for (int r = 0; r < ROW; r++) begin
            for (int c = 0; c < COL; c++) begin
                result_nxt[(r*COL+c)*WIDTH +: WIDTH] =
                    narrow(acc[r][c] + (acc_mode_q ? sext_w(result_in[(r*COL+c)*WIDTH +: WIDTH]) : '0));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (a_take) a_mem[a_r][a_k] <= data_in_a;
        if (b_take) b_mem[b_k][b_c] <= data_in_b;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            req_in     <= 1'b0;
            req_w      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result_out <= '0;
            tag_out    <= '0;
            acc_mode_q <= 1'b0;
            tag_q      <= '0;
            a_r        <= '0;
            a_k        <= '0;
            b_k        <= '0;
            b_c        <= '0;
            k_cnt      <= '0;
            for (int r = 0; r < ROW; r++)
                for (int c = 0; c < COL; c++)
                    acc[r][c] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (en) begin
                        acc_mode_q <= acc_mode;
                        tag_q      <= tag_in;
                        a_r        <= '0;
                        a_k        <= '0;
                        b_k        <= '0;
                        b_c        <= '0;
                        req_in     <= 1'b1;
                        req_w      <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_LOAD;
                        for (int r = 0; r < ROW; r++)
                            for (int c = 0; c < COL; c++)
                                acc[r][c] <= '0;
                    end
                end
                S_LOAD: begin
                    if (a_take) begin
                        if (a_k == KW'(KDIM-1)) begin
                            a_k <= '0;
                            a_r <= a_r + 1'b1;
                        end else begin
                            a_k <= a_k + 1'b1;
                        end
                    end
                    if (b_take) begin
                        if (b_c == CW'(COL-1)) begin
                            b_c <= '0;
                            b_k <= b_k + 1'b1;
                        end else begin
                            b_c <= b_c + 1'b1;
                        end
                    end
                    if (a_last) req_in <= 1'b0;
                    if (b_last) req_w  <= 1'b0;
                    if (a_fin && b_fin) begin
                        k_cnt <= KW'(KDIM-1);
                        state <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    // k walks downward; summation order does not affect the exact result
                    for (int r = 0; r < ROW; r++)
                        for (int c = 0; c < COL; c++)
                            acc[r][c] <= acc[r][c] + mac_term(a_mem[r][k_cnt], b_mem[k_cnt][c]);
                    if (k_cnt == '0)
                        state <= S_WRITE;
                    else
                        k_cnt <= k_cnt - 1'b1;
                end
                S_WRITE: begin
                    result_out <= result_nxt;
                    tag_out    <= tag_q;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
